spi_fetch: RTL and testbench

SPI_FETCH -- requirements
Module: spi_fetch

---
 rtl/spi_fetch.sv | 171 +++++++++++++++++
 tb/tb_spi_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fetch.sv
// SPI NOR instruction fetcher: issues READ (0x03) + 24-bit address, then
// streams bytes into a one-deep output register with a valid/ready handshake.
// The receive shift register acts as a second buffer stage (HOLD state).
module spi_fetch #(
    parameter int SPI_CLK_DIV = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [23:0] jump_addr,
    output logic [7:0]  instr_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        CSHI,
        CMD,
        DATA,
        HOLD
    } state_t;

    localparam int DW = (SPI_CLK_DIV > 0) ? $clog2(SPI_CLK_DIV + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SPI_CLK_DIV);

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] div_cnt;
    logic          phase;
    logic [4:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic [7:0]    rx_sr;

    logic shifting;
    logic phase_end;
    logic rise_edge;
    logic bit_end;
    logic bit_last;
    logic byte_done;
    logic handshake;
    logic load_new;
    logic load_held;

    // Phase/bit timing strobes derived from the divider and bit counter
    always_comb begin
        shifting  = (state == CMD) || (state == DATA);
        phase_end = (div_cnt == DIV_LAST);
        rise_edge = shifting && phase_end && !phase;
        bit_end   = shifting && phase_end && phase;
        bit_last  = (state == CMD) ? (bit_cnt == 5'd31) : (bit_cnt == 5'd7);
        byte_done = (state == DATA) && bit_end && (bit_cnt == 5'd7);
        handshake = instr_valid && instr_ready;
        load_new  = byte_done && (!instr_valid || instr_ready);
        load_held = (state == HOLD) && instr_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and SPI pin decode
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        spi_cs_n = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                spi_cs_n = 1'b1;
            end
            CSHI: begin
                spi_cs_n = 1'b1;
                if (bit_cnt == 5'd1) begin
                    state_nx = CMD;
                end
            end
            CMD: begin
                spi_sclk = phase;
                spi_mosi = tx_sr[31];
                if (bit_end && bit_last) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                spi_sclk = phase;
                if (byte_done && !load_new) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_nx = DATA;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (jump) begin
            state_nx = CSHI;
        end
    end

    // SCLK divider, bit counter and shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (jump) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            tx_sr   <= {8'h03, jump_addr};
            rx_sr   <= '0;
        end else begin
            case (state)
                CSHI: begin
                    bit_cnt <= (bit_cnt == 5'd1) ? 5'd0 : bit_cnt + 5'd1;
                end
                CMD, DATA: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (rise_edge && (state == DATA)) begin
                        rx_sr <= {rx_sr[6:0], spi_miso};
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_last ? 5'd0 : bit_cnt + 5'd1;
                        if (state == CMD) begin
                            tx_sr <= {tx_sr[30:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register: a load at the same edge as a handshake keeps valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr_data  <= '0;
        end else if (jump) begin
            instr_valid <= 1'b0;
        end else if (load_new || load_held) begin
            instr_valid <= 1'b1;
            instr_data  <= rx_sr;
        end else if (handshake) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_fetch.sv
// Bench for spi_fetch: SPI flash model at the pins, scoreboard queues for
// the command word and the delivered byte stream, plus timing probes.
module tb_spi_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [23:0] jump_addr = '0;
    logic [7:0]  instr_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    logic        rst3 = 1'b1;
    logic        jump3 = 1'b0;
    logic [23:0] jump_addr3 = 24'h000010;
    logic [7:0]  instr_data3;
    logic        instr_valid3;
    logic        instr_ready3 = 1'b1;
    logic        busy3;
    logic        cs3;
    logic        sclk3;
    logic        mosi3;
    logic        miso3 = 1'b0;

    spi_fetch #(.SPI_CLK_DIV(0)) dut (
        .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr),
        .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_fetch #(.SPI_CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst3), .jump(jump3), .jump_addr(jump_addr3),
        .instr_data(instr_data3), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
        .busy(busy3), .spi_cs_n(cs3), .spi_sclk(sclk3),
        .spi_mosi(mosi3), .spi_miso(miso3)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flash contents: fixed bytes at 0x012345.., a simple hash elsewhere
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012345: return 8'hA5;
            24'h012346: return 8'h3C;
            24'h012347: return 8'hFF;
            default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    logic [31:0]  cmd_q[$];
    logic [7:0]   data_q[$];
    int unsigned  hs_cyc_q[$];

    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;
    int          rise_cnt = 0;
    int          any_rises = 0;
    logic [31:0] cmd_sr = '0;
    logic [23:0] fl_addr = '0;

    // Flash model and output monitor, evaluated on the falling clock edge
    always @(negedge clk) begin : mon
        int n;
        logic [7:0] b;
        if (spi_sclk && !prev_sclk) any_rises++;
        if (spi_cs_n) begin
            rise_cnt = 0;
            spi_miso = 1'b0;
            if (spi_mosi !== 1'b0) check_val("mosi_idle", {31'd0, spi_mosi}, 32'd0);
        end else begin
            if (spi_sclk && !prev_sclk) begin
                rise_cnt++;
                if (rise_cnt <= 32) cmd_sr = {cmd_sr[30:0], spi_mosi};
                if (rise_cnt == 32) begin
                    fl_addr = cmd_sr[23:0];
                    if (cmd_q.size() == 0) check_val("cmd_unexpected", cmd_sr, 32'hFFFF_FFFF);
                    else check_val("cmd_word", cmd_sr, cmd_q.pop_front());
                end
            end
            if (!spi_sclk && prev_sclk && rise_cnt >= 32) begin
                n = rise_cnt - 32;
                b = flash_byte(fl_addr + 24'(n / 8));
                spi_miso = b[7 - (n % 8)];
            end
            if (spi_sclk && prev_sclk && spi_mosi !== prev_mosi)
                check_val("mosi_stable_hi", {31'd0, spi_mosi}, {31'd0, prev_mosi});
            if (rise_cnt >= 32 && !spi_sclk && spi_mosi !== 1'b0)
                check_val("mosi_data", {31'd0, spi_mosi}, 32'd0);
        end
        if (prev_hold && instr_valid && instr_data !== prev_data)
            check_val("data_stable", {24'd0, instr_data}, {24'd0, prev_data});
        if (instr_valid && instr_ready && !rst) begin
            hs_cyc_q.push_back(cyc);
            if (data_q.size() == 0) check_val("hs_unexpected", {24'd0, instr_data}, 32'h100);
            else check_val("instr_data", {24'd0, instr_data}, {24'd0, data_q.pop_front()});
        end
        prev_hold = instr_valid && !instr_ready && !jump && !rst;
        prev_data = instr_data;
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
    end

    // Drive a one-cycle jump (called just after a rising edge) and load expectations
    task automatic do_jump(input logic [23:0] a);
        jump = 1'b1;
        jump_addr = a;
        @(posedge clk); #1;
        jump = 1'b0;
        cmd_q.delete();
        data_q.delete();
        cmd_q.push_back({8'h03, a});
        for (int i = 0; i < 8; i++) data_q.push_back(flash_byte(a + 24'(i)));
    endtask

    task automatic wait_valid(input int limit, input string tag);
        int k;
        k = 0;
        while (!instr_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (!instr_valid) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_cs_n"},  {31'd0, spi_cs_n}, 32'd1);
        check_val({tag, "_sclk"},  {31'd0, spi_sclk}, 32'd0);
        check_val({tag, "_mosi"},  {31'd0, spi_mosi}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check_val({tag, "_data"},  {24'd0, instr_data}, 32'd0);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    int unsigned t0;
    int unsigned c_fall;
    int          r;
    int          k;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Streaming read with ready held high
        @(posedge clk); #1;
        instr_ready = 1'b1;
        hs_cyc_q.delete();
        t0 = cyc;
        do_jump(24'h012345);
        k = 0;
        while (spi_cs_n && k < 10) begin @(negedge clk); k++; end
        check_val("cs_fall_cyc", cyc, t0 + 3);
        wait_valid(200, "first_valid");
        check_val("first_valid_cyc", cyc, t0 + 83);
        k = 0;
        while (hs_cyc_q.size() < 3 && k < 100) begin @(negedge clk); k++; end
        check_val("hs_count", hs_cyc_q.size(), 3);
        if (hs_cyc_q.size() >= 3) begin
            check_val("hs_gap1", hs_cyc_q[1] - hs_cyc_q[0], 16);
            check_val("hs_gap2", hs_cyc_q[2] - hs_cyc_q[1], 16);
        end

        // Back-pressure: second byte parks in HOLD
        @(posedge clk); #1;
        instr_ready = 1'b0;
        do_jump(24'h012345);
        wait_valid(200, "hold_valid");
        repeat (24) @(negedge clk);
        check_val("hold_sclk", {31'd0, spi_sclk}, 32'd0);
        check_val("hold_cs_n", {31'd0, spi_cs_n}, 32'd0);
        check_val("hold_data", {24'd0, instr_data}, 32'hA5);
        r = any_rises;
        repeat (10) @(negedge clk);
        check_val("hold_no_sclk", any_rises, r);
        check_val("hold_data_late", {24'd0, instr_data}, 32'hA5);
        hs_cyc_q.delete();
        @(posedge clk); #1;
        instr_ready = 1'b1;
        r = any_rises;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        instr_ready = 1'b0;
        check_val("release_hs", hs_cyc_q.size(), 2);
        repeat (3) @(negedge clk);
        check_val("sclk_resume", {31'd0, any_rises > r}, 32'd1);
        repeat (40) @(negedge clk);
        check_val("hold2_sclk", {31'd0, spi_sclk}, 32'd0);
        check_val("hold2_data", {24'd0, instr_data}, 32'hFF);

        // Jump out of HOLD
        @(posedge clk); #1;
        t0 = cyc;
        do_jump(24'h000100);
        @(negedge clk);
        check_val("jump_valid_clr", {31'd0, instr_valid}, 32'd0);
        check_val("jump_cs_hi1", {31'd0, spi_cs_n}, 32'd1);
        @(negedge clk);
        check_val("jump_cs_hi2", {31'd0, spi_cs_n}, 32'd1);
        @(negedge clk);
        check_val("jump_cs_lo", {31'd0, spi_cs_n}, 32'd0);
        wait_valid(200, "jump_valid");
        check_val("jump_valid_cyc", cyc, t0 + 83);
        hs_cyc_q.delete();
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        check_val("jump_hs", hs_cyc_q.size(), 1);

        // Reset in the middle of the command phase
        do_jump(24'hABCDEF);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_q.delete();
        data_q.delete();
        @(negedge clk);
        check_idle("rst_cmd");
        r = any_rises;
        repeat (80) @(negedge clk);
        check_val("rst_no_sclk", any_rises, r);
        check_val("rst_still_idle", {31'd0, spi_cs_n}, 32'd1);

        // Simultaneous jump and reset: reset wins
        do_jump(24'h111111);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        jump = 1'b1;
        jump_addr = 24'h222222;
        @(posedge clk); #1;
        rst = 1'b0;
        jump = 1'b0;
        cmd_q.delete();
        data_q.delete();
        @(negedge clk);
        check_idle("rst_jump");
        r = any_rises;
        repeat (80) @(negedge clk);
        check_val("rst_jump_no_sclk", any_rises, r);
        check_val("rst_jump_busy", {31'd0, busy}, 32'd0);

        // Divided SCLK instance
        @(posedge clk); #1;
        jump3 = 1'b1;
        @(posedge clk); #1;
        jump3 = 1'b0;
        k = 0;
        while (cs3 && k < 10) begin @(negedge clk); k++; end
        c_fall = cyc;
        k = 0;
        while (!sclk3 && k < 20) begin @(negedge clk); k++; end
        check_val("div3_first_low", k, 4);
        k = 0;
        while (sclk3 && k < 20) begin @(negedge clk); k++; end
        check_val("div3_high", k, 4);
        k = 0;
        while (!sclk3 && k < 20) begin @(negedge clk); k++; end
        check_val("div3_low", k, 4);
        k = 0;
        while (!instr_valid3 && k < 600) begin @(negedge clk); k++; end
        check_val("div3_first_valid", cyc - c_fall, 320);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
